// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter; done pulses WIDTH+1 clocks after start, start is ignored while busy.
// Optional SIGNED_INPUT_EN: bin_in is two's complement, magnitude is converted and the sign appears on neg.
module bin2bcd_seq #(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 3,
    parameter int LZ_BLANK = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic [3:0]       hundreds,
    output logic [3:0]       tens,
    output logic [3:0]       ones
`ifdef SIGNED_INPUT_EN
    ,
    output logic             neg
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = 4 * DIGITS;
    localparam int PD = (DIGITS < 3) ? 3 : DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [SW-1:0]    scratch;
    logic [SW-1:0]    corr;
    logic [CW-1:0]    cnt;
    logic             last_shift;
    logic [WIDTH-1:0] mag;
    logic [4*PD-1:0]  pad;
    logic [3:0]       hund_fmt;
    logic [3:0]       tens_fmt;
    logic [3:0]       ones_fmt;
`ifdef SIGNED_INPUT_EN
    logic             neg_cap;
`endif

    assign last_shift = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last_shift) state_nxt = LATCH;
            LATCH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);

`ifdef SIGNED_INPUT_EN
        // -bin_in at WIDTH bits maps the most-negative code onto its own unsigned magnitude
        mag = bin_in[WIDTH-1] ? -bin_in : bin_in;
`else
        mag = bin_in;
`endif

        // Per-nibble +3 correction; a corrected digit never exceeds 4'hC, so no carry between nibbles
        corr = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                corr[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end

        pad = '0;
        pad[SW-1:0] = scratch;
        hund_fmt = pad[11:8];
        tens_fmt = pad[7:4];
        ones_fmt = pad[3:0];
        if (LZ_BLANK != 0) begin
            if (pad[11:8] == 4'd0) begin
                hund_fmt = 4'hF;
                if (pad[7:4] == 4'd0) begin
                    tens_fmt = 4'hF;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            scratch  <= '0;
            cnt      <= '0;
            done     <= 1'b0;
            hundreds <= 4'h0;
            tens     <= 4'h0;
            ones     <= 4'h0;
`ifdef SIGNED_INPUT_EN
            neg_cap  <= 1'b0;
            neg      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg   <= mag;
                        scratch <= '0;
                        cnt     <= '0;
`ifdef SIGNED_INPUT_EN
                        neg_cap <= bin_in[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    {scratch, shreg} <= {corr, shreg} << 1;
                    cnt              <= cnt + CW'(1);
                end
                LATCH: begin
                    hundreds <= hund_fmt;
                    tens     <= tens_fmt;
                    ones     <= ones_fmt;
                    done     <= 1'b1;
`ifdef SIGNED_INPUT_EN
                    neg      <= neg_cap;
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and random checks of bin2bcd_seq against an arithmetic (div/mod) reference model.
module tb_bin2bcd_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, start0;
    logic [7:0] bin_in, bin0;
    logic       busy, done, busy0, done0;
    logic [3:0] hundreds, tens, ones, hundreds0, tens0, ones0;
`ifdef SIGNED_INPUT_EN
    logic       neg, neg0;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.WIDTH(8), .DIGITS(3), .LZ_BLANK(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
        .busy(busy), .done(done), .hundreds(hundreds), .tens(tens), .ones(ones)
`ifdef SIGNED_INPUT_EN
        , .neg(neg)
`endif
    );

    bin2bcd_seq #(.WIDTH(8), .DIGITS(3), .LZ_BLANK(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .bin_in(bin0),
        .busy(busy0), .done(done0), .hundreds(hundreds0), .tens(tens0), .ones(ones0)
`ifdef SIGNED_INPUT_EN
        , .neg(neg0)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int magnitude(input logic [7:0] v);
`ifdef SIGNED_INPUT_EN
        return v[7] ? 256 - int'(v) : int'(v);
`else
        return int'(v);
`endif
    endfunction

    function automatic logic [11:0] expect_digits(input int m, input bit lz);
        logic [3:0] hd, td, od;
        hd = 4'(m / 100);
        td = 4'((m / 10) % 10);
        od = 4'(m % 10);
        if (lz && hd == 4'd0) begin
            hd = 4'hF;
            if (td == 4'd0) td = 4'hF;
        end
        return {hd, td, od};
    endfunction

    // One full conversion on the blanking instance, checking latency, busy and digits
    task automatic conv(input string tag, input logic [7:0] v);
        int  n;
        bit  got;
        bit  busy_ok;
        @(negedge clk);
        start  = 1'b1;
        bin_in = v;
        @(posedge clk); #1;
        start = 1'b0;
        busy_ok = (busy === 1'b1);
        n = 0;
        got = 0;
        while (!got && n < 30) begin
            @(posedge clk); #1;
            n++;
            if (done === 1'b1) got = 1;
            else if (busy !== 1'b1) busy_ok = 0;
        end
        chk({tag, "_latency"}, 32'(n), 32'd9);
        chk({tag, "_busy_during"}, 32'(busy_ok), 32'd1);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        chk({tag, "_digits"}, {20'd0, hundreds, tens, ones}, {20'd0, expect_digits(magnitude(v), 1'b1)});
`ifdef SIGNED_INPUT_EN
        chk({tag, "_neg"}, 32'(neg), 32'(v[7]));
`endif
        @(posedge clk); #1;
        chk({tag, "_done_once"}, 32'(done), 32'd0);
    endtask

    initial begin
        int        ndone, e1, e2, e;
        bit        hold_ok;
        logic [11:0] d1, d2;
        logic [7:0]  rv;

        rst_n = 1'b0; start = 1'b0; start0 = 1'b0; bin_in = '0; bin0 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", {busy, done, hundreds, tens, ones}, 14'd0);
        @(negedge clk); rst_n = 1'b1;

        // Reset in the middle of a conversion aborts it
        @(negedge clk); start = 1'b1; bin_in = 8'd255;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_state", {busy, done, hundreds, tens, ones}, 14'd0);
        @(negedge clk); rst_n = 1'b1;
        ndone = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("midrst_no_done", 32'(ndone), 32'd0);
        chk("midrst_idle", 32'(busy), 32'd0);

        conv("v255", 8'd255);
        conv("v0",   8'd0);
        conv("v7",   8'd7);
        conv("v40",  8'd40);
        conv("v100", 8'd100);
`ifdef SIGNED_INPUT_EN
        conv("s80", 8'h80);
        conv("sFF", 8'hFF);
        conv("s7F", 8'h7F);
`endif

        // Restart during a conversion is ignored; restart on the done cycle is accepted
        @(negedge clk); start = 1'b1; bin_in = 8'd200;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk); start = 1'b1; bin_in = 8'd12;
        @(posedge clk); #1; start = 1'b0;
        ndone = 0; e1 = 0; e2 = 0; d1 = '0; d2 = '0;
        for (e = 4; e <= 25; e++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    e1 = e; d1 = {hundreds, tens, ones};
                    start = 1'b1; bin_in = 8'd12;
                end else begin
                    e2 = e; d2 = {hundreds, tens, ones};
                end
            end
        end
        chk("repulse_done_count", 32'(ndone), 32'd2);
        chk("repulse_edge1", 32'(e1), 32'd9);
        chk("repulse_digits1", {20'd0, d1}, {20'd0, expect_digits(200, 1'b1)});
        chk("repulse_edge2", 32'(e2), 32'd19);
        chk("repulse_digits2", {20'd0, d2}, {20'd0, 12'hF12});

        // Unblanked instance: raw digits and hold behaviour
        @(negedge clk); start0 = 1'b1; bin0 = 8'd5;
        @(posedge clk); #1; start0 = 1'b0;
        ndone = 0;
        for (e = 1; e <= 30 && ndone == 0; e++) begin
            @(posedge clk); #1;
            if (done0) ndone = e;
        end
        chk("raw5_latency", 32'(ndone), 32'd9);
        chk("raw5_digits", {20'd0, hundreds0, tens0, ones0}, {20'd0, 12'h005});
        hold_ok = 1;
        repeat (20) begin
            @(posedge clk); #1;
            if (done0 !== 1'b0 || {hundreds0, tens0, ones0} !== 12'h005) hold_ok = 0;
        end
        chk("raw5_hold", 32'(hold_ok), 32'd1);

        // Random values against the arithmetic model
        for (int i = 0; i < 24; i++) begin
            rv = 8'($urandom_range(0, 255));
            conv("rand", rv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter for the calculator output unit.
- Takes the 8-bit ALU result and produces hundreds/tens/ones BCD digits that feed three BCD-to-seven-segment decoders.
- Uses iterative double-dabble: one shift per clock, with a start/done handshake.
- Optional leading-zero blanking drives code 4'hF. The decoders treat any code >9 as blank.

Parameters:
- WIDTH, 8, binary input width. Supported range is 4..9. DIGITS must satisfy 10^DIGITS > 2^WIDTH-1.
- DIGITS, 3, number of BCD digits produced.
- LZ_BLANK, 1, when 1, leading zero digits (except ones) are output as 4'hF.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; samples bin_in.
- bin_in  in  WIDTH  binary value to convert.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when new digits are valid.
- hundreds  out  4  BCD digit 2 (or 4'hF when blanked).
- tens  out  4  BCD digit 1 (or 4'hF when blanked).
- ones  out  4  BCD digit 0. Never blanked.
- neg  out  1  sign flag. Present only with SIGNED_INPUT_EN.

Behaviour:
- Reset (async, rst_n=0):
  - State becomes IDLE; busy=0, done=0, neg=0.
  - hundreds, tens and ones are all 4'h0.
  - Internal shift/BCD registers and the counter are cleared.
- FSM states: IDLE, SHIFT, LATCH.
- IDLE:
  - On a clk edge with start=1, capture the magnitude of bin_in into the shift register.
  - Clear the BCD scratch register and set the counter to 0.
  - Go to SHIFT and set busy=1.
- SHIFT, each edge:
  - Every scratch digit >=5 gets +3.
  - Then {scratch, shift} shifts left by 1.
  - Counter increments. After WIDTH shifts, go to LATCH.
- LATCH, one edge:
  - Copy scratch digits to the outputs, applying blanking.
  - done=1 for exactly this cycle; busy=0.
  - Return to IDLE.
- Latency: if start is sampled at edge k, the outputs update and done rises at edge k+WIDTH+1. busy is high from edge k through edge k+WIDTH+1.
- Digit outputs hold their last values between conversions. They change only at LATCH.
- start while busy=1 is ignored; there is no queueing. start and bin_in are don't-care outside IDLE.
- A start arriving in the same cycle that done is high is accepted, because the FSM is already back in IDLE at that edge.
- Blanking (LZ_BLANK=1): hundreds=4'hF if its digit is 0. tens=4'hF if hundreds is blanked and tens is 0. ones always shows its digit, so a value of 0 displays "0".
- With LZ_BLANK=0, digits are always raw BCD.
- Arithmetic: scratch is 4*DIGITS bits wide. The +3 correction is per-nibble and never carries across nibbles. Overflow cannot occur within the parameter constraint.
- Reset asserted mid-conversion aborts it. No done pulse is produced and the outputs return to reset values.

Optional Feature:
Macro SIGNED_INPUT_EN.
- Defined:
  - bin_in is two's complement.
  - At capture: neg is latched to bin_in[WIDTH-1] (driven on the neg port at LATCH), and the shift register loads |bin_in| at WIDTH bits, unsigned. The most-negative value 8'h80 converts to magnitude 128.
  - The neg port exists. It updates at LATCH together with the digits and resets to 0.
- Not defined:
  - bin_in is unsigned (0..2^WIDTH-1).
  - The neg port and its logic are absent.

Test Plan:
- Reset then idle: rst_n low mid-run -> busy=0, done=0, digits 0/0/0. No done pulse follows after release.
- start with bin_in=8'd255 at edge k -> done pulses only at edge k+9. hundreds=2, tens=5, ones=5. busy is high k..k+9.
- LZ_BLANK=1 sequence:
  - bin_in=0 -> F,F,0.
  - bin_in=7 -> F,F,7.
  - bin_in=40 -> F,4,0.
  - bin_in=100 -> 1,0,0.
- start re-pulsed at edge k+3 with bin_in=12 during conversion of 200 -> exactly one done, digits 2,0,0. A start on the done cycle with 12 then yields F,1,2 nine edges later.
- LZ_BLANK=0, bin_in=5 -> 0,0,5. Outputs hold 0,0,5 for 20 idle cycles with no further done.
- SIGNED_INPUT_EN:
  - bin_in=8'h80 -> neg=1, 1,2,8.
  - bin_in=8'hFF -> neg=1, F,F,1.
  - bin_in=8'h7F -> neg=0, 1,2,7.
